// File: rtl/pixel_fifo_if.sv
// Pixel stream bundle between the display DMA producer and the pixel
// converter consumer. The FIFO sits on the slave side.
//
// Handshake: a word moves on a rising clk edge exactly when valid and ready
// are both high. The sender holds valid and data stable until that edge.
// ready never depends combinationally on valid.
interface pixel_fifo_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    // Buffer side: accepts the producer stream and presents the consumer stream.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    // Environment side: drives the producer stream and consumes the output.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pixel_fifo.sv
// Single-clock pixel FIFO with a registered first-word-fall-through output.
// Storage is a (DEPTH-1)-word RAM plus the output register, so the total
// capacity is exactly DEPTH. The RAM pointers wrap by explicit compare because
// DEPTH-1 is not a power of two.
module pixel_fifo #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 512,
    parameter int AFULL  = DEPTH - 16,
    parameter int AEMPTY = 16,
    parameter int DROP   = 0
) (
    input  logic                   clk,
    input  logic                   resetn,
    pixel_fifo_if.slave            px,
    input  logic                   flush,
    input  logic                   ovf_clr,
    output logic [$clog2(DEPTH):0] level,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [15:0]            ovf_count
);

    localparam int LW        = $clog2(DEPTH) + 1;
    localparam int RAM_WORDS = DEPTH - 1;
    localparam int PW        = $clog2(DEPTH - 1);

    // Registered state
    logic [WIDTH-1:0] ram [RAM_WORDS];
    logic             alive_q;      // 0 only while in reset, 1 from the first edge after
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [LW-1:0]    level_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic             afull_q;
    logic             aempty_q;
    logic [15:0]      ovf_q;

    // Combinational controls
    logic             full;
    logic [LW-1:0]    ram_cnt;
    logic             ram_empty;
    logic             wr_en;
    logic             rd_en;
    logic             drop;
    logic             slot_free;
    logic             load_ram;
    logic             load_thru;
    logic             ram_wr;
    logic [LW-1:0]    level_nxt;

    // Advance a RAM pointer, wrapping after the last RAM word.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RAM_WORDS - 1)) ? '0 : p + PW'(1);
    endfunction

    // Status derived purely from registered state; the output word is not in the RAM.
    assign full      = (level_q == LW'(DEPTH));
    assign ram_cnt   = level_q - LW'(out_valid_q);
    assign ram_empty = (ram_cnt == '0);

    // in_ready looks only at registers, so there is no path from out_ready.
    assign px.in_ready = (DROP != 0) ? alive_q : (alive_q && !full);

    // Transfers; a flush cycle ignores both sides.
    assign wr_en = px.in_valid && alive_q && !full && !flush;
    assign rd_en = out_valid_q && px.out_ready && !flush;
    assign drop  = (DROP != 0) && px.in_valid && alive_q && full && !flush;

    // Output register refills when empty or being read: from RAM first,
    // otherwise straight from the incoming word when the RAM holds nothing.
    assign slot_free = !out_valid_q || rd_en;
    assign load_ram  = slot_free && !ram_empty && !flush;
    assign load_thru = slot_free && ram_empty && wr_en;
    assign ram_wr    = wr_en && !load_thru;

    // Next fill level: up on write-only, down on read-only, cleared by flush.
    always_comb begin
        level_nxt = level_q;
        if (flush) begin
            level_nxt = '0;
        end else if (wr_en && !rd_en) begin
            level_nxt = level_q + LW'(1);
        end else if (rd_en && !wr_en) begin
            level_nxt = level_q - LW'(1);
        end
    end

    // Control, pointers, output register and status flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            alive_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            level_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
        end else begin
            alive_q  <= 1'b1;
            level_q  <= level_nxt;
            afull_q  <= (level_nxt >= LW'(AFULL));
            aempty_q <= (level_nxt <= LW'(AEMPTY));
            if (flush) begin
                out_valid_q <= 1'b0;
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
            end else begin
                if (ram_wr) begin
                    wr_ptr_q <= ptr_inc(wr_ptr_q);
                end
                if (load_ram) begin
                    out_data_q  <= ram[rd_ptr_q];
                    out_valid_q <= 1'b1;
                    rd_ptr_q    <= ptr_inc(rd_ptr_q);
                end else if (load_thru) begin
                    out_data_q  <= px.in_data;
                    out_valid_q <= 1'b1;
                end else if (rd_en) begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

    // RAM write port; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            ram[wr_ptr_q] <= px.in_data;
        end
    end

    // Saturating count of discarded writes; a clear in the same cycle wins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ovf_q <= '0;
        end else if (ovf_clr) begin
            ovf_q <= '0;
        end else if (drop && (ovf_q != 16'hFFFF)) begin
            ovf_q <= ovf_q + 16'd1;
        end
    end

    assign px.out_valid = out_valid_q;
    assign px.out_data  = out_data_q;
    assign level        = level_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign ovf_count    = ovf_q;

endmodule

// File: tb/tb_pixel_fifo.sv
// Bench for pixel_fifo: one backpressure instance and one drop-mode instance,
// both 16 deep, compared each cycle against queue-based reference models.
module tb_pixel_fifo;

    localparam int W = 16;
    localparam int D = 16;

    // Clock and reset
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    pixel_fifo_if #(.WIDTH(W)) bus0 ();
    pixel_fifo_if #(.WIDTH(W)) bus1 ();

    logic        flush0, clr0, flush1, clr1;
    logic [4:0]  level0, level1;
    logic        af0, ae0, af1, ae1;
    logic [15:0] ovf0, ovf1;

    pixel_fifo #(.WIDTH(W), .DEPTH(D), .AFULL(12), .AEMPTY(2), .DROP(0)) dut0 (
        .clk(clk), .resetn(resetn), .px(bus0), .flush(flush0), .ovf_clr(clr0),
        .level(level0), .almost_full(af0), .almost_empty(ae0), .ovf_count(ovf0)
    );

    pixel_fifo #(.WIDTH(W), .DEPTH(D), .AFULL(12), .AEMPTY(2), .DROP(1)) dut1 (
        .clk(clk), .resetn(resetn), .px(bus1), .flush(flush1), .ovf_clr(clr1),
        .level(level1), .almost_full(af1), .almost_empty(ae1), .ovf_count(ovf1)
    );

    // Scoreboard state
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp1_q[$];
    int           ovf_m = 0;
    int           total = 0;
    int           bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check0();
        int n;
        n = exp_q.size();
        check("level0", 32'(level0), n);
        check("out_valid0", 32'(bus0.out_valid), 32'(n > 0));
        if (n > 0) check("out_data0", 32'(bus0.out_data), 32'(exp_q[0]));
        check("in_ready0", 32'(bus0.in_ready), 32'(n < D));
        check("almost_full0", 32'(af0), 32'(n >= 12));
        check("almost_empty0", 32'(ae0), 32'(n <= 2));
        check("ovf0", 32'(ovf0), 0);
    endtask

    task automatic check1();
        int n;
        n = exp1_q.size();
        check("level1", 32'(level1), n);
        check("out_valid1", 32'(bus1.out_valid), 32'(n > 0));
        if (n > 0) check("out_data1", 32'(bus1.out_data), 32'(exp1_q[0]));
        check("in_ready1", 32'(bus1.in_ready), 1);
        check("almost_full1", 32'(af1), 32'(n >= 12));
        check("almost_empty1", 32'(ae1), 32'(n <= 2));
        check("ovf1", 32'(ovf1), ovf_m);
    endtask

    // Drive one cycle into the backpressure FIFO, update the model, check at negedge.
    task automatic step0(input logic iv, input logic [W-1:0] id, input logic ordy, input logic fl);
        logic wr, rd;
        logic [W-1:0] tmp;
        bus0.in_valid  = iv;
        bus0.in_data   = id;
        bus0.out_ready = ordy;
        flush0         = fl;
        wr = iv && (exp_q.size() < D);
        rd = ordy && (exp_q.size() > 0);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (rd) tmp = exp_q.pop_front();
            if (wr) exp_q.push_back(id);
        end
        @(posedge clk);
        @(negedge clk);
        bus0.in_valid = 1'b0;
        bus0.out_ready = 1'b0;
        flush0 = 1'b0;
        check0();
    endtask

    // Drive one cycle into the drop-mode FIFO.
    task automatic step1(input logic iv, input logic [W-1:0] id, input logic ordy, input logic clr);
        logic [W-1:0] tmp;
        logic full;
        bus1.in_valid  = iv;
        bus1.in_data   = id;
        bus1.out_ready = ordy;
        clr1           = clr;
        full = (exp1_q.size() == D);
        if (ordy && exp1_q.size() > 0) tmp = exp1_q.pop_front();
        if (iv && !full) exp1_q.push_back(id);
        if (clr) ovf_m = 0;
        else if (iv && full && ovf_m < 65535) ovf_m++;
        @(posedge clk);
        @(negedge clk);
        bus1.in_valid = 1'b0;
        bus1.out_ready = 1'b0;
        clr1 = 1'b0;
        check1();
    endtask

    initial begin
        int rd_expect;
        int next_word;
        int cyc;
        logic iv, ordy;

        bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
        flush0 = 1'b0; clr0 = 1'b0; flush1 = 1'b0; clr1 = 1'b0;

        // Reset values while held in reset
        repeat (2) @(negedge clk);
        check("rst_level", 32'(level0), 0);
        check("rst_out_valid", 32'(bus0.out_valid), 0);
        check("rst_out_data", 32'(bus0.out_data), 0);
        check("rst_in_ready", 32'(bus0.in_ready), 0);
        check("rst_in_ready1", 32'(bus1.in_ready), 0);
        check("rst_afull", 32'(af0), 0);
        check("rst_aempty", 32'(ae0), 1);
        check("rst_ovf1", 32'(ovf1), 0);
        resetn = 1'b1;
        step0(1'b0, '0, 1'b0, 1'b0);
        check1();

        // Fill to full with the consumer stalled, then one refused write
        for (int i = 0; i < 16; i++) step0(1'b1, W'(i), 1'b0, 1'b0);
        step0(1'b1, W'(16), 1'b0, 1'b0);
        // Drain
        for (int i = 0; i < 17; i++) step0(1'b0, '0, 1'b1, 1'b0);

        // Random concurrent traffic across many RAM wraps
        rd_expect = 0;
        next_word = 0;
        cyc = 0;
        while (rd_expect < 1000 && cyc < 8000) begin
            iv   = (next_word < 1000) && ($urandom_range(0, 1) == 1);
            ordy = ($urandom_range(0, 1) == 1);
            if (bus0.out_valid && ordy) begin
                check("stream", 32'(bus0.out_data), 32'(rd_expect));
                rd_expect++;
            end
            if (iv && exp_q.size() < D) begin
                step0(1'b1, W'(next_word), ordy, 1'b0);
                next_word++;
            end else begin
                step0(iv, W'(next_word), ordy, 1'b0);
            end
            cyc++;
        end
        check("stream_len", 32'(rd_expect), 1000);

        // Flush at level 9 while writing
        for (int i = 0; i < 9; i++) step0(1'b1, W'(16'h200 + i), 1'b0, 1'b0);
        step0(1'b1, 16'h0BAD, 1'b0, 1'b1);
        check("flush_level", 32'(level0), 0);
        check("flush_out_valid", 32'(bus0.out_valid), 0);
        step0(1'b1, 16'hABCD, 1'b0, 1'b0);
        check("flush_first_word", 32'(bus0.out_data), 32'h0000ABCD);
        for (int i = 0; i < 3; i++) step0(1'b0, '0, 1'b1, 1'b0);

        // Drop mode: fill, overflow by 20, clear in a drop cycle, drain
        for (int i = 0; i < 16; i++) step1(1'b1, W'(i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step1(1'b1, W'(100 + i), 1'b0, 1'b0);
        check("ovf_20", 32'(ovf1), 20);
        step1(1'b1, 16'h7777, 1'b0, 1'b1);
        check("ovf_clr", 32'(ovf1), 0);
        for (int i = 0; i < 17; i++) step1(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step1(1'b1, W'(16'h300 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step1(1'b1, '1, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle at level 7
        for (int i = 0; i < 7; i++) step0(1'b1, W'(16'h400 + i), 1'b0, 1'b0);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("arst_level", 32'(level0), 0);
        check("arst_out_valid", 32'(bus0.out_valid), 0);
        check("arst_in_ready", 32'(bus0.in_ready), 0);
        check("arst_ovf1", 32'(ovf1), 0);
        check("arst_level1", 32'(level1), 0);
        exp_q.delete();
        exp1_q.delete();
        ovf_m = 0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        step0(1'b0, '0, 1'b0, 1'b0);
        check1();
        for (int i = 0; i < 40; i++)
            step0($urandom_range(0, 1) == 1, W'($urandom), $urandom_range(0, 1) == 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
